// File: rtl/queue_ctrl_pkg.sv
// Shared sizing constants for the lab2 queue datapath.
package queue_ctrl_pkg;
  localparam int Q_WIDTH    = 4;
  localparam int Q_AW       = 3;
  localparam int Q_DEPTH    = 2**Q_AW;
  localparam int Q_SCAN_DIV = 4;
endpackage

// File: rtl/queue_ctrl_reg_file.sv
// DEPTH x WIDTH storage: one synchronous write port, two asynchronous reads
// (queue head and display scan), cleared asynchronously on rst.
module queue_ctrl_reg_file
  import queue_ctrl_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int AW    = Q_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd,
  input  logic [AW-1:0]    sa,
  output logic [WIDTH-1:0] sd
);
  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we && wa == AW'(i)) mem[i] <= wd;
    end
  end

  assign rd = mem[ra];
  assign sd = mem[sa];
endmodule

// File: rtl/queue_ctrl.sv
// Circular FIFO fed by single-cycle strobes, with a free-running scan port
// that walks every slot for the display stage.
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int WIDTH    = Q_WIDTH,
  parameter int AW       = Q_AW,
  parameter int SCAN_DIV = Q_SCAN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             en_out,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic [AW-1:0]    scan_addr,
  output logic [WIDTH-1:0] scan_data,
  output logic             scan_valid,
  output logic             scan_head
);
  localparam int DEPTH = 2**AW;
  localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [AW-1:0]    rd_ptr, wr_ptr, scan_off;
  logic [WIDTH-1:0] head;
  logic [DW-1:0]    div;
  logic             do_enq, do_deq;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_deq = en_out & ~empty;
  // A simultaneous dequeue frees the slot, so a full queue still accepts.
  assign do_enq = en_in & (~full | do_deq);

  queue_ctrl_reg_file #(.WIDTH(WIDTH), .AW(AW)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (do_enq),
    .wa  (wr_ptr),
    .wd  (in),
    .ra  (rd_ptr),
    .rd  (head),
    .sa  (scan_addr),
    .sd  (scan_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      out    <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) begin
        rd_ptr <= rd_ptr + 1'b1;
        out    <= head;
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      scan_addr <= '0;
    end else if (div == DW'(SCAN_DIV-1)) begin
      div       <= '0;
      scan_addr <= scan_addr + 1'b1;
    end else begin
      div       <= div + 1'b1;
    end
  end

  // Distance from the head, modulo DEPTH, tells whether the slot is live.
  assign scan_off   = scan_addr - rd_ptr;
  assign scan_valid = ({1'b0, scan_off} < count);
  assign scan_head  = (scan_addr == rd_ptr) && !empty;
endmodule

// File: tb/tb_queue_ctrl.sv
// Directed plus random stimulus against a queue-based reference model.
module tb_queue_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_in, en_out;
  logic [3:0] in;
  logic [3:0] out;
  logic       empty, full;
  logic [3:0] count;
  logic [2:0] scan_addr;
  logic [3:0] scan_data;
  logic       scan_valid, scan_head;

  int checks = 0;
  int errors = 0;

  // reference model
  int         q[$];
  logic [3:0] mmem[8];
  int         rdp, wrp, ncyc;
  logic [3:0] mout;

  queue_ctrl dut (
    .clk(clk), .rst(rst), .en_in(en_in), .en_out(en_out), .in(in),
    .out(out), .empty(empty), .full(full), .count(count),
    .scan_addr(scan_addr), .scan_data(scan_data),
    .scan_valid(scan_valid), .scan_head(scan_head)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sa;
    sa = (ncyc / 4) % 8;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full",  32'(full),  32'(q.size() == 8));
    chk("out",   32'(out),   32'(mout));
    chk("scan_addr",  32'(scan_addr),  32'(sa));
    chk("scan_data",  32'(scan_data),  32'(mmem[sa]));
    chk("scan_valid", 32'(scan_valid), 32'(((sa - rdp + 8) % 8) < q.size()));
    chk("scan_head",  32'(scan_head),  32'(sa == rdp && q.size() > 0));
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) mmem[i] = 4'h0;
    rdp = 0; wrp = 0; ncyc = 0; mout = 4'h0;
  endtask

  // Pulse rst between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
  endtask

  task automatic cyc(input bit e, input bit d, input logic [3:0] v);
    bit de, dd;
    en_in = e; en_out = d; in = v;
    @(posedge clk); #1;
    dd = d && q.size() > 0;
    de = e && (q.size() < 8 || dd);
    if (dd) begin mout = 4'(q.pop_front()); rdp = (rdp + 1) % 8; end
    if (de) begin q.push_back(int'(v)); mmem[wrp] = v; wrp = (wrp + 1) % 8; end
    ncyc++;
    en_in = 1'b0; en_out = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; en_in = 1'b0; en_out = 1'b0; in = 4'h0;
    model_reset();
    #7;
    do_reset();

    // basic order
    cyc(1, 0, 4'd3); cyc(0, 0, 0); cyc(1, 0, 4'd5); cyc(0, 0, 0); cyc(1, 0, 4'd9);
    chk("t1_count3", 32'(count), 32'd3);
    cyc(0, 1, 0); chk("t1_out3", 32'(out), 32'd3);
    cyc(0, 1, 0); chk("t1_out5", 32'(out), 32'd5);
    cyc(0, 1, 0); chk("t1_out9", 32'(out), 32'd9);
    chk("t1_empty", 32'(empty), 32'd1);

    // dequeue on empty holds out
    cyc(0, 1, 0); cyc(0, 1, 0);
    chk("t3_out_hold", 32'(out), 32'd9);

    // fill, overflow drop, drain
    for (int i = 1; i <= 8; i++) cyc(1, 0, 4'(i));
    cyc(1, 0, 4'hF);
    chk("t2_full", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0);
      chk("t2_drain", 32'(out), 32'(i));
    end

    // wrap-around with scan sweep
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 0, 4'(i + 1));
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    cyc(1, 0, 4'hA); cyc(1, 0, 4'hB); cyc(1, 0, 4'hC);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0);

    // simultaneous strobes while full
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, 0, 4'(i));
    cyc(1, 1, 4'hE);
    chk("t5_out1", 32'(out), 32'd1);
    chk("t5_count8", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    chk("t5_lastE", 32'(out), 32'hE);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1, 0, 4'(i + 2));
    cyc(0, 1, 0);
    do_reset();
    chk("t6_out0", 32'(out), 32'd0);
    cyc(1, 0, 4'd7); cyc(0, 1, 0);
    chk("t6_out7", 32'(out), 32'd7);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
